// File: rtl/rom_region_loader.sv
// Routes the byte-serial ROM download to NREG regions, packing BYTES-wide words; one word write 1 cycle after its last byte.
// No backpressure: one byte per cycle is always accepted; out-of-sequence bytes are dropped and flagged.
module rom_region_loader #(
  parameter int                  NREG        = 8,
  parameter int                  BYTES       = 1,
  parameter int                  AW          = 16,
  parameter logic [NREG*25-1:0]  REGION_BASE = '0,
  parameter logic [NREG*25-1:0]  REGION_SIZE = '0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IOCTL_DOWNLOAD,
  input  logic                  IOCTL_WR,
  input  logic [24:0]           IOCTL_ADDR,
  input  logic [7:0]            IOCTL_DATA,
  output logic [NREG-1:0]       ROM_WR,
  output logic [AW-1:0]         ROM_ADDR,
  output logic [8*BYTES-1:0]    ROM_DATA,
  output logic [NREG-1:0]       REGION_FULL,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int LB = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_dl_q;
  logic                    w_rise;
  logic                    w_start;
  logic                    w_finish;
  logic                    w_byte;

  logic [24:0]             r_exp;
  logic                    r_err;
  logic                    r_load_err;
  logic [BYTES-1:0][7:0]   r_buf;
  logic [BYTES-1:0][7:0]   w_word;
  logic [24:0]             r_cnt [NREG];
  logic [24:0]             w_base [NREG];
  logic [24:0]             w_size [NREG];

  logic [NREG-1:0]         r_rom_wr;
  logic [AW-1:0]           r_rom_addr;
  logic [8*BYTES-1:0]      r_rom_data;

  logic                    w_hit;
  logic [IW-1:0]           w_idx;
  logic [24:0]             w_off;
  logic [24:0]             w_lane;
  logic                    w_last;
  logic                    w_seq_ok;
  logic [AW-1:0]           w_waddr;

  // r_dl_q resets high so a download already asserted at reset release is not a rise.
  assign w_rise = IOCTL_DOWNLOAD & ~r_dl_q;

  for (genvar g = 0; g < NREG; g++) begin : g_region
    assign w_base[g]      = REGION_BASE[25*g +: 25];
    assign w_size[g]      = REGION_SIZE[25*g +: 25];
    assign REGION_FULL[g] = (r_cnt[g] == w_size[g]);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_byte      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_rise) begin
          w_state_nxt = S_LOAD;
          w_start     = 1'b1;
        end
      end
      S_LOAD: begin
        if (!IOCTL_DOWNLOAD) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
        end else begin
          w_byte = IOCTL_WR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_off = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!w_hit && (IOCTL_ADDR >= w_base[i]) &&
          ({1'b0, IOCTL_ADDR} < ({1'b0, w_base[i]} + {1'b0, w_size[i]}))) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
        w_off = IOCTL_ADDR - w_base[i];
      end
    end
  end

  assign w_lane   = w_off & 25'(BYTES - 1);
  assign w_last   = (w_lane == 25'(BYTES - 1));
  assign w_seq_ok = (IOCTL_ADDR == r_exp);
  assign w_waddr  = AW'(w_off >> LB);

  always_comb begin
    w_word = r_buf;
    for (int b = 0; b < BYTES; b++) begin
      if (w_lane == 25'(b)) begin
        w_word[b] = IOCTL_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dl_q     <= 1'b1;
      r_exp      <= '0;
      r_err      <= 1'b0;
      r_load_err <= 1'b0;
      r_buf      <= '0;
      r_rom_wr   <= '0;
      r_rom_addr <= '0;
      r_rom_data <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_dl_q   <= IOCTL_DOWNLOAD;
      r_rom_wr <= '0;
      if (w_start) begin
        r_exp      <= '0;
        r_err      <= 1'b0;
        r_load_err <= 1'b0;
        r_buf      <= '0;
        for (int i = 0; i < NREG; i++) begin
          r_cnt[i] <= '0;
        end
      end else if (w_finish) begin
        // A trailing partial word leaves its region short, which shows up here.
        r_load_err <= r_err | ~(&REGION_FULL);
      end else if (w_byte) begin
        if (!w_seq_ok) begin
          r_err <= 1'b1;
        end else begin
          r_exp <= r_exp + 25'd1;
          if (w_hit) begin
            r_buf <= w_word;
            if (r_cnt[w_idx] != w_size[w_idx]) begin
              r_cnt[w_idx] <= r_cnt[w_idx] + 25'd1;
            end
            if (w_last) begin
              r_rom_wr   <= NREG'(1) << w_idx;
              r_rom_addr <= w_waddr;
              r_rom_data <= w_word;
            end
          end
        end
      end
    end
  end

  assign ROM_WR    = r_rom_wr;
  assign ROM_ADDR  = r_rom_addr;
  assign ROM_DATA  = r_rom_data;
  assign LOAD_DONE = (r_state == S_DONE);
  assign LOAD_ERR  = r_load_err;

endmodule

// File: tb/tb_rom_region_loader.sv
// Randomized bench for rom_region_loader: 3 regions of 2-byte words with a gap, checked against an address-level model.
module tb_rom_region_loader;

  localparam int NREG  = 3;
  localparam int BYTES = 2;
  localparam int AW    = 16;
  localparam logic [NREG*25-1:0] BASES = {25'h300, 25'h100, 25'h000};
  localparam logic [NREG*25-1:0] SIZES = {25'h100, 25'h100, 25'h100};

  logic        CLK;
  logic        RESET_N;
  logic        IOCTL_DOWNLOAD;
  logic        IOCTL_WR;
  logic [24:0] IOCTL_ADDR;
  logic [7:0]  IOCTL_DATA;
  logic [2:0]  ROM_WR;
  logic [15:0] ROM_ADDR;
  logic [15:0] ROM_DATA;
  logic [2:0]  REGION_FULL;
  logic        LOAD_DONE;
  logic        LOAD_ERR;

  rom_region_loader #(
    .NREG(NREG), .BYTES(BYTES), .AW(AW),
    .REGION_BASE(BASES), .REGION_SIZE(SIZES)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_WR(IOCTL_WR),
    .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DATA(IOCTL_DATA),
    .ROM_WR(ROM_WR), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .REGION_FULL(REGION_FULL), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          stamp;
    logic [2:0]  wr;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  exp_t        q[$];
  exp_t        e;

  bit          m_active;
  int          m_exp;
  bit          m_err;
  int          m_cnt [3];
  logic [7:0]  img [0:1023];

  int          pc [3];
  int          n_wr;
  logic [2:0]  first_wr;
  logic [15:0] first_addr;
  logic [15:0] first_data;
  bit          cap_seen;
  logic [15:0] cap_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Write monitor: every observed pulse must match the next expected write and its cycle.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].stamp < cyc) begin
      chk("wr_missed", 32'(q[0].addr), 32'hFFFF_FFFF);
      void'(q.pop_front());
    end
    if (ROM_WR != 3'b000) begin
      if (n_wr == 0) begin
        first_wr   = ROM_WR;
        first_addr = ROM_ADDR;
        first_data = ROM_DATA;
      end
      n_wr++;
      for (int r = 0; r < 3; r++) if (ROM_WR[r]) pc[r]++;
      if (ROM_WR == 3'b010 && ROM_ADDR == 16'h0) begin
        cap_seen = 1'b1;
        cap_data = ROM_DATA;
      end
      if (q.size() == 0) begin
        chk("wr_unexpected", 32'(ROM_WR), 32'h0);
      end else begin
        e = q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e.stamp));
        chk("wr_onehot", 32'(ROM_WR), 32'(e.wr));
        chk("wr_addr", 32'(ROM_ADDR), 32'(e.addr));
        chk("wr_data", 32'(ROM_DATA), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int region_of(input int a);
    if (a >= 'h000 && a < 'h100) return 0;
    if (a >= 'h100 && a < 'h200) return 1;
    if (a >= 'h300 && a < 'h400) return 2;
    return -1;
  endfunction

  function automatic logic [2:0] model_full();
    logic [2:0] f;
    for (int r = 0; r < 3; r++) f[r] = (m_cnt[r] == 'h100);
    return f;
  endfunction

  task automatic send_byte(input int a, input logic [7:0] d);
    int   r;
    int   off;
    exp_t x;
    IOCTL_WR   = 1'b1;
    IOCTL_ADDR = 25'(a);
    IOCTL_DATA = d;
    if (m_active) begin
      if (a != m_exp) begin
        m_err = 1'b1;
      end else begin
        m_exp++;
        r = region_of(a);
        if (r >= 0) begin
          off    = a - r * 'h100 - ((r == 2) ? 'h100 : 0);
          img[a] = d;
          if (m_cnt[r] < 'h100) m_cnt[r]++;
          if (off % 2 == 1) begin
            x.stamp = cyc + 1;
            x.wr    = 3'(1 << r);
            x.addr  = 16'(off / 2);
            x.data  = {d, img[a-1]};
            q.push_back(x);
          end
        end
      end
    end
    tick();
    IOCTL_WR = 1'b0;
  endtask

  task automatic stream(input int lo, input int hi, input int skip, input int dmode, input int bad_pct);
    logic [7:0] d;
    for (int a = lo; a <= hi; a++) begin
      if (a == skip) continue;
      if ($urandom_range(0, 99) < bad_pct) send_byte(a + 1 + int'($urandom_range(0, 5)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
      d = (dmode == 0) ? 8'(a) : 8'($urandom);
      if (dmode == 1 && a == 'h100) d = 8'hAA;
      if (dmode == 1 && a == 'h101) d = 8'h55;
      send_byte(a, d);
    end
  endtask

  task automatic start_download(input bit was_done);
    IOCTL_DOWNLOAD = 1'b1;
    if (was_done) begin
      @(negedge CLK);
      chk("done_hold_on_rise", 32'(LOAD_DONE), 32'h1);
    end
    tick();
    @(negedge CLK);
    chk("done_clear", 32'(LOAD_DONE), 32'h0);
    chk("full_clear", 32'(REGION_FULL), 32'h0);
    m_active = 1'b1;
    m_exp    = 0;
    m_err    = 1'b0;
    n_wr     = 0;
    cap_seen = 1'b0;
    for (int r = 0; r < 3; r++) begin
      m_cnt[r] = 0;
      pc[r]    = 0;
    end
    tick();
  endtask

  task automatic end_download(input logic [2:0] want_full, input bit want_err);
    IOCTL_DOWNLOAD = 1'b0;
    IOCTL_WR       = 1'b1;
    IOCTL_ADDR     = 25'(m_exp);
    IOCTL_DATA     = 8'($urandom);
    @(negedge CLK);
    chk("done_not_early", 32'(LOAD_DONE), 32'h0);
    tick();
    IOCTL_WR = 1'b0;
    @(negedge CLK);
    chk("done_rise", 32'(LOAD_DONE), 32'h1);
    chk("load_err", 32'(LOAD_ERR), 32'(want_err));
    chk("region_full", 32'(REGION_FULL), 32'(want_full));
    chk("region_full_model", 32'(REGION_FULL), 32'(model_full()));
    chk("load_err_model", 32'(LOAD_ERR), 32'(m_err | (model_full() != 3'b111)));
    m_active = 1'b0;
    tick();
  endtask

  task automatic check_full_run();
    chk("pulses_r0", 32'(pc[0]), 32'd128);
    chk("pulses_r1", 32'(pc[1]), 32'd128);
    chk("pulses_r2", 32'(pc[2]), 32'd128);
    chk("first_wr", 32'(first_wr), 32'h1);
    chk("first_addr", 32'(first_addr), 32'h0);
    chk("first_data", 32'(first_data), 32'h0100);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rom_wr"}, 32'(ROM_WR), 32'h0);
    chk({tag, "_rom_addr"}, 32'(ROM_ADDR), 32'h0);
    chk({tag, "_rom_data"}, 32'(ROM_DATA), 32'h0);
    chk({tag, "_full"}, 32'(REGION_FULL), 32'h0);
    chk({tag, "_done"}, 32'(LOAD_DONE), 32'h0);
    chk({tag, "_err"}, 32'(LOAD_ERR), 32'h0);
  endtask

  initial begin
    RESET_N        = 1'b0;
    IOCTL_DOWNLOAD = 1'b0;
    IOCTL_WR       = 1'b0;
    IOCTL_ADDR     = '0;
    IOCTL_DATA     = '0;
    m_active       = 1'b0;
    n_wr           = 0;
    for (int a = 0; a < 1024; a++) img[a] = 8'h00;
    tick();
    tick();
    check_outputs_zero("reset");
    RESET_N = 1'b1;
    tick();

    // Full sequential stream, data = address low byte.
    start_download(1'b0);
    stream('h000, 'h3FF, -1, 0, 0);
    end_download(3'b111, 1'b0);
    check_full_run();

    // Second download from DONE, random data with 0xAA/0x55 pinned at 0x100/0x101.
    start_download(1'b1);
    stream('h000, 'h3FF, -1, 1, 0);
    end_download(3'b111, 1'b0);
    chk("aa55_seen", 32'(cap_seen), 32'h1);
    chk("aa55_word", 32'(cap_data), 32'h55AA);

    // Missing byte 0x050: everything after it is dropped.
    start_download(1'b1);
    stream('h000, 'h3FF, 'h050, 1, 0);
    end_download(3'b000, 1'b1);
    chk("skip_pulses_r0", 32'(pc[0]), 32'd40);
    chk("skip_pulses_r1", 32'(pc[1]), 32'd0);

    // Download dropped after byte 0x180 (mid-word).
    start_download(1'b1);
    stream('h000, 'h180, -1, 1, 0);
    end_download(3'b001, 1'b1);

    // Random stray addresses; the correct bytes still land.
    start_download(1'b1);
    send_byte('h155, 8'h11);
    stream('h000, 'h3FF, -1, 1, 3);
    end_download(3'b111, 1'b1);
    chk("stray_pulses_r2", 32'(pc[2]), 32'd128);

    // Reset mid-load at byte 0x120.
    start_download(1'b1);
    stream('h000, 'h120, -1, 0, 0);
    tick();
    RESET_N  = 1'b0;
    q.delete();
    m_active = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick();
    RESET_N = 1'b1;
    tick();
    send_byte('h000, 8'h12);
    send_byte('h001, 8'h34);
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    chk("no_load_without_rise", 32'(LOAD_DONE), 32'h0);
    tick();

    start_download(1'b0);
    stream('h000, 'h3FF, -1, 0, 0);
    end_download(3'b111, 1'b0);
    check_full_run();

    for (int i = 0; i < 4; i++) tick();
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rom_region_loader.md
# rom_region_loader

Parametrised download-stream demultiplexer for arcade cores. Takes the byte-serial ROM download stream and routes each byte to one of NREG on-chip ROM regions defined by a base/size table. Packs bytes into BYTES-wide words and tracks per-region fill. Reports load completion and error status to the core's reset/boot logic. Replaces hand-written address selectors plus per-EPROM write gating.

## Interface
Parameters:
- NREG, 8: number of ROM regions (1..16).
- BYTES, 1: bytes per output word; legal values 1, 2, 4.
- AW, 16: width of ROM_ADDR (local word address).
- REGION_BASE, 0: packed NREG×25-bit byte base addresses. Region i is in bits [25i+24:25i]. Ascending order, non-overlapping.
- REGION_SIZE, 0: packed NREG×25-bit byte sizes, same packing. Each size is nonzero, a multiple of BYTES, and ≤ BYTES·2^AW.

Ports:
- CLK, in, 1: system clock.
- RESET_N, in, 1: asynchronous, active-low reset.
- IOCTL_DOWNLOAD, in, 1: download in progress.
- IOCTL_WR, in, 1: one-cycle byte strobe; valid only while IOCTL_DOWNLOAD=1.
- IOCTL_ADDR, in, 25: byte address of IOCTL_DATA.
- IOCTL_DATA, in, 8: download byte.
- ROM_WR, out, NREG: one-hot word write strobe, one bit per region.
- ROM_ADDR, out, AW: word address within the selected region.
- ROM_DATA, out, 8·BYTES: packed word, little-endian (lowest address in bits [7:0]).
- REGION_FULL, out, NREG: region i received exactly REGION_SIZE[i] bytes.
- LOAD_DONE, out, 1: download finished; level signal.
- LOAD_ERR, out, 1: error status; valid while LOAD_DONE=1.

## Operation
- State machine states: IDLE, LOAD, DONE.
- IDLE → LOAD on the rising edge of IOCTL_DOWNLOAD.
  - Clear region counters, REGION_FULL, the sticky error flag, the lane buffer, and the expected address (set to 0).
- DONE → LOAD on the rising edge of IOCTL_DOWNLOAD, with the same clears.
- LOAD → DONE when IOCTL_DOWNLOAD falls.
  - LOAD_ERR = sticky error flag OR (REGION_FULL ≠ all ones).
- Sequence check in LOAD, on each IOCTL_WR:
  - IOCTL_ADDR ≠ expected address: set sticky error, drop the byte, leave the expected address unchanged.
  - Otherwise: expected address increments by 1.
- Decode: a byte belongs to region i when BASE[i] ≤ addr < BASE[i]+SIZE[i].
  - Bytes in no region (gaps, or past the last region) are dropped silently. They advance the expected address and are not errors.
- Packing:
  - Local offset = addr − BASE[i].
  - Lane = offset mod BYTES. The byte is stored in lane buffer slot `lane`.
  - When lane = BYTES−1: ROM_WR[i] pulses and ROM_ADDR = offset / BYTES.
  - ROM_DATA = buffer with the current byte merged in.
  - BYTES=1: every byte produces a write.
- Region counter i increments per accepted byte and saturates at SIZE[i]. REGION_FULL[i] = (count == SIZE[i]).
- If IOCTL_DOWNLOAD falls mid-word, the partial word is discarded. The region is then not full, so LOAD_ERR=1.
- IOCTL_WR with IOCTL_DOWNLOAD=0 is ignored in every state.

## Timing
- Reset values: ROM_WR=0, ROM_ADDR=0, ROM_DATA=0, REGION_FULL=0, LOAD_DONE=0, LOAD_ERR=0, state=IDLE.
- Reset asserted mid-load:
  - Everything returns to reset values immediately, with no write pulse.
  - After release the block waits for a fresh IOCTL_DOWNLOAD rise; a download already high is not treated as a rise.
- ROM_WR latency: 1 cycle after the IOCTL_WR of a word's last byte. Pulse width is 1 cycle; ROM_ADDR/ROM_DATA are valid in the same cycle.
- REGION_FULL[i] updates in the same cycle as the write of the region's last word.
- LOAD_DONE/LOAD_ERR rise 1 cycle after IOCTL_DOWNLOAD is sampled low. They fall 1 cycle after IOCTL_DOWNLOAD is sampled high again.
- Throughput: one byte per cycle; back-to-back IOCTL_WR is supported.
- IOCTL_WR in the same cycle as the IOCTL_DOWNLOAD falling edge is ignored.

## Test plan
Common configuration: NREG=3, BYTES=2, bases 0x000/0x100/0x300, sizes 0x100 each (gap at 0x200–0x2FF).
- Full sequential stream 0x000–0x3FF, data = addr[7:0]:
  - 128 pulses on each of ROM_WR[0], ROM_WR[1], ROM_WR[2]; no pulses for the gap.
  - First write: ROM_WR=3'b001, ROM_ADDR=0, ROM_DATA=0x0100.
  - End: REGION_FULL=3'b111, LOAD_DONE=1, LOAD_ERR=0.
- Bytes 0x100=0xAA and 0x101=0x55 → one cycle after 0x101: ROM_WR=3'b010, ROM_ADDR=0, ROM_DATA=0x55AA.
- Stream with 0x050 skipped:
  - No write for word 0x28.
  - Data from address 0x051 onward is dropped.
  - After download ends: LOAD_DONE=1, LOAD_ERR=1.
- Download dropped after byte 0x180: REGION_FULL=3'b001, LOAD_DONE=1, LOAD_ERR=1.
- RESET_N pulsed low at byte 0x120:
  - All outputs 0.
  - Next full download gives the same result as the first scenario.
- Second download after DONE: LOAD_DONE falls 1 cycle after the rise and REGION_FULL clears to 0.
